swap_pair_monitor: RTL
======================

Name: swap_pair_monitor

Overview:
- Checking end of the two-bit registered a/b interface used by the nonblocking swap stage.
- Records each input pair (a_i, b_i) presented to the DUT and predicts the DUT outputs LATENCY cycles later.
- Compares the prediction with the DUT outputs (a_o, b_o), then counts checks and mismatches and captures the first failure.
- Self-checking component for benches and the on-chip debug wrapper; it never drives the DUT.

Parameters:
LATENCY, 1, DUT input-to-output delay in cycles; legal range 1..8.
CW, 16, width of the check counter, error counter and first-error index.
MAX_ERR, 8, error count that forces HALT; 0 disables halting.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  1 = push a new check every cycle; 0 = stop pushing and drain.
mode  in  1  0 = swap (exp a_o = b_i, exp b_o = a_i); 1 = pass (exp a_o = a_i, exp b_o = b_i).
a_i  in  1  a value presented to the DUT this cycle.
b_i  in  1  b value presented to the DUT this cycle.
a_o  in  1  DUT a output.
b_o  in  1  DUT b output.
busy  out  1  high in RUN or DRAIN.
halted  out  1  high in HALT.
err  out  1  sticky; set on first mismatch.
err_cnt  out  CW  mismatching comparisons, saturating.
chk_cnt  out  CW  comparisons performed, saturating.
first_err_idx  out  CW  chk_cnt value (0-based) at the first mismatch.
first_err_bits  out  2  {a mismatch, b mismatch} at the first mismatch.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs become 0.
  - Expected/valid pipeline is cleared.
  - Reset mid-run discards in-flight entries; no comparison happens in the reset cycle.
- Pipeline:
  - LATENCY-deep shift register of {valid, exp_a, exp_b}; shifts every cycle.
  - Head entry: valid = (state is RUN, or IDLE with en=1) and en=1; exp pair per mode sampled that cycle.
  - mode is captured on the IDLE->RUN transition; mode changes during RUN or DRAIN are ignored.
- Compare: when the tail entry is valid, compare exp_a vs a_o and exp_b vs b_o in that cycle.
  - chk_cnt += 1, saturating at all-ones.
  - Mismatch on either bit: err_cnt += 1 (saturating) and err <= 1.
  - On the first mismatch only, also capture first_err_idx = pre-increment chk_cnt and first_err_bits.
- FSM:
  - IDLE: en=1 -> RUN. The same edge clears chk_cnt, err_cnt, err and the first_err_* fields, and pushes the first valid entry.
  - RUN: en=0 -> DRAIN (no push that cycle); err_cnt reaching MAX_ERR (MAX_ERR!=0) -> HALT.
  - DRAIN: in-flight entries are still compared.
    - Pipeline holds no valid entries after this edge -> IDLE.
    - en=1 returns to RUN without clearing counters.
    - MAX_ERR reached -> HALT.
  - HALT: no push, no compare, counters frozen. Exit by rst only.
- Simultaneous events:
  - The MAX_ERR-reaching mismatch is counted before halting.
  - en=0 and HALT condition on the same edge -> HALT wins.
- Latency: an input sampled at edge t is checked against the DUT outputs present at edge t+LATENCY.
- Counter saturation: chk_cnt and err_cnt hold at 2^CW-1. Saturation never sets err by itself.

Test Plan:
- Swap DUT, LATENCY=1, mode=0, a_i=1, b_i=0 for 10 cycles then en=0 -> chk_cnt=10, err=0, err_cnt=0; busy falls one cycle after en falls.
- Same bench with b_o forced 0 at check 3 -> err=1, err_cnt=1, first_err_idx=3, first_err_bits=2'b01.
- Pass-through DUT, LATENCY=3, mode=1, random a_i/b_i for 20 cycles -> chk_cnt=20, err=0; first compare occurs 3 cycles after en rises.
- MAX_ERR=8 with the DUT inverting a_o -> halted=1 after the 8th check, err_cnt=8, chk_cnt=8; counters frozen for 20 further cycles.
- rst pulsed during RUN with 2 entries in flight (LATENCY=3) -> all outputs 0 next cycle, no late comparison counted; re-enabling starts chk_cnt from 0.
- CW=4, 20 clean checks -> chk_cnt saturates at 15, err=0.

Source files
------------

// File: rtl/swap_pair_monitor.sv
// -----------------------------------------------------------------------------
// swap_pair_monitor
//
// Checking end of the two-bit registered a/b swap stage. Every cycle the
// monitor is enabled it predicts the DUT output pair for the current input
// pair (swapped or passed through), delays the prediction by LATENCY cycles
// and compares it with the DUT outputs. It counts comparisons and mismatches,
// keeps a sticky error flag and records where the first mismatch happened.
// It only observes the DUT and never drives it.
//
// Parameters:
//   LATENCY  DUT input-to-output delay in cycles (1..8)
//   CW       width of chk_cnt, err_cnt and first_err_idx
//   MAX_ERR  error count that forces HALT; 0 disables halting
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   en              in   1 = push a check every cycle, 0 = stop and drain
//   mode            in   0 = swap, 1 = pass (captured when leaving IDLE)
//   a_i, b_i        in   pair presented to the DUT this cycle
//   a_o, b_o        in   DUT outputs
//   busy            out  high in RUN or DRAIN
//   halted          out  high in HALT
//   err             out  sticky mismatch flag
//   err_cnt         out  mismatching comparisons, saturating
//   chk_cnt         out  comparisons performed, saturating
//   first_err_idx   out  chk_cnt value at the first mismatch
//   first_err_bits  out  {a mismatch, b mismatch} at the first mismatch
// -----------------------------------------------------------------------------
module swap_pair_monitor #(
  parameter int LATENCY = 1,
  parameter int CW      = 16,
  parameter int MAX_ERR = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic          a_i,
  input  logic          b_i,
  input  logic          a_o,
  input  logic          b_o,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] chk_cnt,
  output logic [CW-1:0] first_err_idx,
  output logic [1:0]    first_err_bits
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [31:0]   MAX_ERR_U = 32'(MAX_ERR);

  // Expected DUT output pair {a_o, b_o} for a given mode and input pair.
  function automatic logic [1:0] exp_pair(input logic m, input logic a, input logic b);
    logic [1:0] p;
    if (m) begin
      p = {a, b};
    end else begin
      p = {b, a};
    end
    return p;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{(CW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t             r_state;
  logic               r_mode;
  logic [LATENCY-1:0] r_pipe_v;
  logic [LATENCY-1:0] r_pipe_a;
  logic [LATENCY-1:0] r_pipe_b;
  logic               r_busy;
  logic               r_halted;
  logic               r_err;
  logic [CW-1:0]      r_err_cnt;
  logic [CW-1:0]      r_chk_cnt;
  logic [CW-1:0]      r_first_idx;
  logic [1:0]         r_first_bits;

  logic               w_push;
  logic               w_mode_sel;
  logic [1:0]         w_head;
  logic [LATENCY-1:0] w_pipe_v_nxt;
  logic [LATENCY-1:0] w_pipe_a_nxt;
  logic [LATENCY-1:0] w_pipe_b_nxt;
  logic               w_cmp;
  logic [1:0]         w_miss;
  logic               w_mismatch;
  logic [CW-1:0]      w_chk_nxt;
  logic [CW-1:0]      w_errc_nxt;
  logic               w_err_nxt;
  logic [CW-1:0]      w_fidx_nxt;
  logic [1:0]         w_fbits_nxt;
  logic [31:0]        w_errc_ext;
  logic               w_halt_hit;

  // Head entry, pipeline shift values, tail comparison and counter updates.
  always_comb begin
    w_push       = 1'b0;
    w_mode_sel   = r_mode;
    w_head       = 2'b00;
    w_pipe_v_nxt = {LATENCY{1'b0}};
    w_pipe_a_nxt = {LATENCY{1'b0}};
    w_pipe_b_nxt = {LATENCY{1'b0}};
    w_cmp        = 1'b0;
    w_miss       = 2'b00;
    w_mismatch   = 1'b0;
    w_chk_nxt    = r_chk_cnt;
    w_errc_nxt   = r_err_cnt;
    w_err_nxt    = r_err;
    w_fidx_nxt   = r_first_idx;
    w_fbits_nxt  = r_first_bits;
    w_errc_ext   = 32'd0;
    w_halt_hit   = 1'b0;

    // Pushing is only possible while running or on the edge that starts a run.
    if ((r_state == ST_IDLE) || (r_state == ST_RUN)) begin
      w_push = en;
    end else begin
      w_push = 1'b0;
    end

    // On the starting edge the live mode input is the one being captured.
    if (r_state == ST_IDLE) begin
      w_mode_sel = mode;
    end else begin
      w_mode_sel = r_mode;
    end

    w_head = exp_pair(w_mode_sel, a_i, b_i);

    w_pipe_v_nxt    = r_pipe_v << 1'b1;
    w_pipe_a_nxt    = r_pipe_a << 1'b1;
    w_pipe_b_nxt    = r_pipe_b << 1'b1;
    w_pipe_v_nxt[0] = w_push;
    w_pipe_a_nxt[0] = w_head[1];
    w_pipe_b_nxt[0] = w_head[0];

    // HALT (and IDLE, which never holds valid entries) performs no compares.
    if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) begin
      w_cmp = r_pipe_v[LATENCY-1];
    end else begin
      w_cmp = 1'b0;
    end

    w_miss     = {r_pipe_a[LATENCY-1] ^ a_o, r_pipe_b[LATENCY-1] ^ b_o};
    w_mismatch = w_cmp && (w_miss != 2'b00);

    if (w_cmp) begin
      w_chk_nxt = sat_inc(r_chk_cnt);
    end else begin
      w_chk_nxt = r_chk_cnt;
    end

    if (w_mismatch) begin
      w_errc_nxt = sat_inc(r_err_cnt);
      w_err_nxt  = 1'b1;
      // Only the first mismatch of a run is recorded; later ones just count.
      if (!r_err) begin
        w_fidx_nxt  = r_chk_cnt;
        w_fbits_nxt = w_miss;
      end else begin
        w_fidx_nxt  = r_first_idx;
        w_fbits_nxt = r_first_bits;
      end
    end else begin
      w_errc_nxt = r_err_cnt;
      w_err_nxt  = r_err;
    end

    // Halt is judged on the post-increment count so the last error is counted.
    w_errc_ext = 32'(w_errc_nxt);
    if ((MAX_ERR_U != 32'd0) && w_mismatch && (w_errc_ext >= MAX_ERR_U)) begin
      w_halt_hit = 1'b1;
    end else begin
      w_halt_hit = 1'b0;
    end
  end

  // Control FSM, expectation pipeline, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= 1'b0;
      r_pipe_v     <= {LATENCY{1'b0}};
      r_pipe_a     <= {LATENCY{1'b0}};
      r_pipe_b     <= {LATENCY{1'b0}};
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= {CW{1'b0}};
      r_chk_cnt    <= {CW{1'b0}};
      r_first_idx  <= {CW{1'b0}};
      r_first_bits <= 2'b00;
    end else begin
      r_pipe_v <= w_pipe_v_nxt;
      r_pipe_a <= w_pipe_a_nxt;
      r_pipe_b <= w_pipe_b_nxt;

      // A fresh run starts from clean counters; otherwise take the update.
      if ((r_state == ST_IDLE) && en) begin
        r_err        <= 1'b0;
        r_err_cnt    <= {CW{1'b0}};
        r_chk_cnt    <= {CW{1'b0}};
        r_first_idx  <= {CW{1'b0}};
        r_first_bits <= 2'b00;
      end else begin
        r_err        <= w_err_nxt;
        r_err_cnt    <= w_errc_nxt;
        r_chk_cnt    <= w_chk_nxt;
        r_first_idx  <= w_fidx_nxt;
        r_first_bits <= w_fbits_nxt;
      end

      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state  <= ST_RUN;
            r_mode   <= mode;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end else begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_halt_hit) begin
            r_state  <= ST_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (!en) begin
            r_state  <= ST_DRAIN;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end else begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_halt_hit) begin
            r_state  <= ST_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (en) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end else if (w_pipe_v_nxt == {LATENCY{1'b0}}) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
          end else begin
            r_state  <= ST_DRAIN;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        ST_HALT: begin
          r_state  <= ST_HALT;
          r_busy   <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign halted         = r_halted;
  assign err            = r_err;
  assign err_cnt        = r_err_cnt;
  assign chk_cnt        = r_chk_cnt;
  assign first_err_idx  = r_first_idx;
  assign first_err_bits = r_first_bits;

endmodule
